// File: rtl/riscv_pkg.sv
// Shared constants, word type and alignment helper for the data memory responder.
package riscv_pkg;

  localparam int          MEM_XLEN                = 32;
  localparam int          MEM_WORD_BYTES          = 4;
  localparam logic [31:0] MEM_TOHOST_ADDR_DEFAULT = 32'h0000_1000;

  typedef logic [MEM_XLEN-1:0] mem_word_t;

  function automatic logic is_word_aligned(input logic [1:0] byte_offset);
    return (byte_offset == 2'b00);
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Data-memory bus between a core (master) and the memory responder (slave).
interface data_mem_responder_if #(
  parameter int XLEN = 32
);

  logic            memory_write_enable;
  logic [XLEN-1:0] memory_address;
  logic [XLEN-1:0] memory_write_data;
  logic [XLEN-1:0] memory_read_data;
  logic            tohost_valid;
  logic [XLEN-1:0] tohost_data;
  logic            halted;
  logic            misaligned_error;
  logic [15:0]     store_count;

  modport master (
    output memory_write_enable, memory_address, memory_write_data,
    input  memory_read_data, tohost_valid, tohost_data, halted,
           misaligned_error, store_count
  );

  modport slave (
    input  memory_write_enable, memory_address, memory_write_data,
    output memory_read_data, tohost_valid, tohost_data, halted,
           misaligned_error, store_count
  );

endinterface

// File: rtl/word_ram.sv
// Word-wide RAM: synchronous write, asynchronous read (old data during a same-cycle write).
module word_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder: address decode, tohost mailbox, error flag and store counter.
// Tohost mailbox/halt enabled by defining DATA_MEM_RESPONDER_TOHOST_EN.
module data_mem_responder
  import riscv_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              DEPTH_WORDS = 1024,
  parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(MEM_TOHOST_ADDR_DEFAULT)
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_responder_if.slave bus
);

  localparam int              IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [XLEN-1:0] RAM_BYTES = XLEN'(DEPTH_WORDS * MEM_WORD_BYTES);

  logic            w_aligned;
  logic            w_in_range;
  logic            w_is_tohost;
  logic            w_halted;
  logic            w_ram_we;
  logic [XLEN-1:0] w_ram_rdata;
  logic [15:0]     r_store_count;
  logic            r_misaligned_error;

  assign w_aligned   = is_word_aligned(bus.memory_address[1:0]);
  assign w_in_range  = (bus.memory_address < RAM_BYTES);
  assign w_is_tohost = (bus.memory_address == TOHOST_ADDR);
  assign w_ram_we    = bus.memory_write_enable & w_aligned & w_in_range & ~w_is_tohost
                       & ~w_halted & ~rst;

  word_ram #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH_WORDS)
  ) u_word_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (bus.memory_address[2 +: IDX_W]),
    .i_wdata (bus.memory_write_data),
    .o_rdata (w_ram_rdata)
  );

  assign bus.memory_read_data = (w_aligned && w_in_range) ? w_ram_rdata : '0;

  // Saturating store counter and sticky misaligned-store flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_store_count      <= 16'h0000;
      r_misaligned_error <= 1'b0;
    end else begin
      if (w_ram_we && (r_store_count != 16'hFFFF)) begin
        r_store_count <= r_store_count + 16'h0001;
      end
      if (bus.memory_write_enable && !w_aligned) begin
        r_misaligned_error <= 1'b1;
      end
    end
  end

  assign bus.store_count      = r_store_count;
  assign bus.misaligned_error = r_misaligned_error;

`ifdef DATA_MEM_RESPONDER_TOHOST_EN
  logic            r_tohost_valid;
  logic            r_halted;
  logic [XLEN-1:0] r_tohost_data;
  logic            w_tohost_we;

  assign w_tohost_we = bus.memory_write_enable & w_aligned & w_is_tohost & ~r_halted;

  // Tohost mailbox: one-cycle valid pulse, held data, sticky halt on bit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tohost_valid <= 1'b0;
      r_tohost_data  <= '0;
      r_halted       <= 1'b0;
    end else begin
      r_tohost_valid <= w_tohost_we;
      if (w_tohost_we) begin
        r_tohost_data <= bus.memory_write_data;
        if (bus.memory_write_data[0]) begin
          r_halted <= 1'b1;
        end
      end
    end
  end

  assign w_halted         = r_halted;
  assign bus.tohost_valid = r_tohost_valid;
  assign bus.tohost_data  = r_tohost_data;
  assign bus.halted       = r_halted;
`else
  assign w_halted         = 1'b0;
  assign bus.tohost_valid = 1'b0;
  assign bus.tohost_data  = '0;
  assign bus.halted       = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus random traffic vs. a reference model.
module tb_data_mem_responder;
  import riscv_pkg::*;

`ifdef DATA_MEM_RESPONDER_TOHOST_EN
  localparam bit TOHOST_EN = 1'b1;
`else
  localparam bit TOHOST_EN = 1'b0;
`endif
  localparam logic [31:0] TOHOST = 32'h0000_1000;
  localparam int          DEPTH  = 1024;

  logic clk = 1'b0;
  logic rst;

  data_mem_responder_if #(.XLEN(32)) bus ();

  data_mem_responder #(
    .XLEN        (32),
    .DEPTH_WORDS (DEPTH),
    .TOHOST_ADDR (TOHOST)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  mem_word_t   m_mem [DEPTH];
  logic        m_tv;
  logic        m_halted;
  logic        m_mis;
  mem_word_t   m_td;
  logic [15:0] m_cnt;

  int errors   = 0;
  int checks   = 0;
  bit auto_chk = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic mem_word_t exp_rd(input logic [31:0] a);
    if (a[1:0] == 2'b00 && a < 32'(DEPTH * 4)) return m_mem[a / 4];
    return '0;
  endfunction

  task automatic setin(input logic r, input logic we, input logic [31:0] a, input logic [31:0] d);
    rst                     = r;
    bus.memory_write_enable = we;
    bus.memory_address      = a;
    bus.memory_write_data   = d;
  endtask

  task automatic model_step();
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    we   = bus.memory_write_enable;
    a    = bus.memory_address;
    d    = bus.memory_write_data;
    m_tv = 1'b0;
    if (rst) begin
      m_td     = '0;
      m_halted = 1'b0;
      m_mis    = 1'b0;
      m_cnt    = 16'h0000;
    end else if (we) begin
      if (a[1:0] != 2'b00) begin
        m_mis = 1'b1;
      end else if (!m_halted) begin
        if (a < 32'(DEPTH * 4)) begin
          m_mem[a / 4] = d;
          if (m_cnt != 16'hFFFF) m_cnt++;
        end else if (TOHOST_EN && a == TOHOST) begin
          m_td = d;
          m_tv = 1'b1;
          if (d[0]) m_halted = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    #1;
    if (auto_chk) check("read_data", bus.memory_read_data, exp_rd(bus.memory_address));
    @(posedge clk);
    model_step();
    #1;
    if (auto_chk) begin
      check("tohost_valid", 32'(bus.tohost_valid), 32'(m_tv));
      check("tohost_data", bus.tohost_data, m_td);
      check("halted", 32'(bus.halted), 32'(m_halted));
      check("misaligned_error", 32'(bus.misaligned_error), 32'(m_mis));
      check("store_count", 32'(bus.store_count), 32'(m_cnt));
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] last_a;
    logic [31:0] last_d;
    logic [15:0] cnt_before;
    int          sel;

    // Reset state
    auto_chk = 1'b0;
    setin(1'b1, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    check("rst_tohost_valid", 32'(bus.tohost_valid), 32'h0);
    check("rst_tohost_data", bus.tohost_data, 32'h0);
    check("rst_halted", 32'(bus.halted), 32'h0);
    check("rst_misaligned", 32'(bus.misaligned_error), 32'h0);
    check("rst_store_count", 32'(bus.store_count), 32'h0);

    // Fill every word so later reads are defined; word 0x20 holds zero
    for (int i = 0; i < DEPTH; i++) begin
      d = (i == 8) ? 32'h0 : $urandom;
      setin(1'b0, 1'b1, 32'(i * 4), d);
      tick();
    end
    setin(1'b1, 1'b0, 32'h0, 32'h0);
    tick();
    auto_chk = 1'b1;

    // Store then read back
    setin(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    tick();
    setin(1'b0, 1'b0, 32'h0000_0010, 32'h0);
    #1;
    check("store_readback", bus.memory_read_data, 32'hDEAD_BEEF);
    check("store_count_one", 32'(bus.store_count), 32'h1);
    tick();

    // Same-cycle read returns the old value
    setin(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678);
    #1;
    check("same_cycle_old", bus.memory_read_data, 32'h0);
    tick();
    setin(1'b0, 1'b0, 32'h0000_0020, 32'h0);
    #1;
    check("next_cycle_new", bus.memory_read_data, 32'h1234_5678);
    tick();

    // Misaligned store is dropped and flagged
    setin(1'b0, 1'b1, 32'h0000_0013, 32'hFFFF_FFFF);
    tick();
    check("misaligned_set", 32'(bus.misaligned_error), 32'h1);
    check("misaligned_count", 32'(bus.store_count), 32'h2);
    setin(1'b0, 1'b0, 32'h0000_0010, 32'h0);
    #1;
    check("misaligned_word_kept", bus.memory_read_data, 32'hDEAD_BEEF);
    tick();

    // Random traffic: reads, aligned stores, misaligned stores, out-of-range stores
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 4);
      d   = $urandom;
      case (sel)
        0:       setin(1'b0, 1'b0, 32'($urandom_range(0, 32'h1FFF)), d);
        1:       setin(1'b0, 1'b1, 32'($urandom_range(0, DEPTH - 1)) * 32'd4, d);
        2:       setin(1'b0, 1'b1, 32'($urandom_range(0, DEPTH - 1)) * 32'd4
                                   + 32'($urandom_range(1, 3)), d);
        3:       setin(1'b0, 1'b1, 32'h0000_2000 + 32'($urandom_range(0, DEPTH - 1)) * 32'd4, d);
        default: setin(1'b0, 1'b0, TOHOST, d);
      endcase
      tick();
    end

`ifdef DATA_MEM_RESPONDER_TOHOST_EN
    setin(1'b1, 1'b0, 32'h0, 32'h0);
    tick();
    setin(1'b0, 1'b1, TOHOST, 32'h0000_0054);
    tick();
    check("tohost_pulse", 32'(bus.tohost_valid), 32'h1);
    check("tohost_data_54", bus.tohost_data, 32'h0000_0054);
    check("tohost_not_halted", 32'(bus.halted), 32'h0);
    setin(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("tohost_pulse_end", 32'(bus.tohost_valid), 32'h0);
    setin(1'b0, 1'b1, TOHOST, 32'h0000_0001);
    tick();
    check("tohost_halt", 32'(bus.halted), 32'h1);
    cnt_before = m_cnt;
    d          = m_mem[0];
    setin(1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF);
    tick();
    setin(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("halted_store_ignored", bus.memory_read_data, d);
    check("halted_count_kept", 32'(bus.store_count), 32'(cnt_before));
    tick();
    setin(1'b1, 1'b0, 32'h0, 32'h0);
    tick();
    setin(1'b0, 1'b1, TOHOST, 32'h0000_0002);
    tick();
    check("tohost_before_rst", 32'(bus.tohost_valid), 32'h1);
    setin(1'b1, 1'b0, 32'h0, 32'h0);
    tick();
    check("tohost_rst_priority", 32'(bus.tohost_valid), 32'h0);
`else
    cnt_before = m_cnt;
    setin(1'b0, 1'b1, TOHOST, 32'h0000_0001);
    tick();
    check("no_tohost_valid", 32'(bus.tohost_valid), 32'h0);
    check("no_tohost_data", bus.tohost_data, 32'h0);
    check("no_tohost_halted", 32'(bus.halted), 32'h0);
    check("no_tohost_count", 32'(bus.store_count), 32'(cnt_before));
`endif

    // Counter saturation followed by reset
    setin(1'b1, 1'b0, 32'h0, 32'h0);
    tick();
    auto_chk = 1'b0;
    last_a   = 32'h0;
    last_d   = 32'h0;
    for (int i = 0; i < 65540; i++) begin
      a = 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
      d = $urandom;
      setin(1'b0, 1'b1, a, d);
      tick();
      last_a = a;
      last_d = d;
    end
    auto_chk = 1'b1;
    setin(1'b0, 1'b0, last_a, 32'h0);
    #1;
    check("count_saturated", 32'(bus.store_count), 32'h0000_FFFF);
    check("sat_last_word", bus.memory_read_data, last_d);
    tick();
    setin(1'b1, 1'b1, last_a, ~last_d);
    tick();
    check("rst2_tohost_valid", 32'(bus.tohost_valid), 32'h0);
    check("rst2_tohost_data", bus.tohost_data, 32'h0);
    check("rst2_halted", 32'(bus.halted), 32'h0);
    check("rst2_misaligned", 32'(bus.misaligned_error), 32'h0);
    check("rst2_store_count", 32'(bus.store_count), 32'h0);
    setin(1'b0, 1'b0, last_a, 32'h0);
    #1;
    check("ram_survives_rst", bus.memory_read_data, last_d);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
